// File: rtl/gpio_bank_pkg.sv
// Shared constants for the GPIO bank: register map addresses and reset value.
package gpio_bank_pkg;

    localparam logic [2:0] ADDR_OUT  = 3'd0;
    localparam logic [2:0] ADDR_DIR  = 3'd1;
    localparam logic [2:0] ADDR_IN   = 3'd2;
    localparam logic [2:0] ADDR_MASK = 3'd3;
    localparam logic [2:0] ADDR_STAT = 3'd4;
    localparam logic [2:0] ADDR_EDGE = 3'd5;
    localparam logic [2:0] ADDR_SET  = 3'd6;
    localparam logic [2:0] ADDR_CLR  = 3'd7;

    // Every register bit comes out of reset at this value.
    localparam logic GPIO_RST_BIT = 1'b0;

endpackage

// File: rtl/apb_gpio_bank_if.sv
// APB bus bundle between the SPI bridge (master) and one GPIO bank (slave).
interface apb_gpio_bank_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready
    );
endinterface

// File: rtl/gpio_sync.sv
// Two-flop synchroniser for asynchronous pin inputs.
// Latency: 2 clk cycles. No backpressure.
module gpio_sync #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);
    logic [DATA_WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/apb_gpio_bank.sv
// APB slave for one GPIO bank: OUT/DIR/IN registers, optional edge interrupts (GPIO_IRQ_EN).
// Latency: fixed one wait state, pready 2 cycles after setup; pins visible in IN 2 cycles after change.
// Backpressure: none beyond the fixed wait state; a dropped psel/penable aborts with no register update.
module apb_gpio_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  pclk,
    input  logic                  presetn,
    apb_gpio_bank_if.slave        apb,
    input  logic [DATA_WIDTH-1:0] gpio_in,
    output logic [DATA_WIDTH-1:0] gpio_out,
    output logic [DATA_WIDTH-1:0] gpio_oe,
    output logic                  irq
);
    import gpio_bank_pkg::*;

    localparam logic [DATA_WIDTH-1:0] RST_VAL = {DATA_WIDTH{GPIO_RST_BIT}};

    logic                  access;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] out_q;
    logic [DATA_WIDTH-1:0] dir_q;
    logic [DATA_WIDTH-1:0] in_sync;
    logic [DATA_WIDTH-1:0] rd_mux;

    assign access = apb.psel & apb.penable;
    assign wr_en  = access & apb.pready & apb.pwrite;

    gpio_sync #(.DATA_WIDTH(DATA_WIDTH)) u_sync (
        .clk   (pclk),
        .rst_n (presetn),
        .d     (gpio_in),
        .q     (in_sync)
    );

`ifdef GPIO_IRQ_EN
    logic [DATA_WIDTH-1:0] mask_q;
    logic [DATA_WIDTH-1:0] stat_q;
    logic [DATA_WIDTH-1:0] edge_q;
    logic [DATA_WIDTH-1:0] hist_q;
    logic [DATA_WIDTH-1:0] evt;
    logic [DATA_WIDTH-1:0] w1c;

    // Per-pin event: rising when edge bit is 0, falling when 1.
    assign evt = (~edge_q & in_sync & ~hist_q) | (edge_q & ~in_sync & hist_q);
    assign w1c = (wr_en && apb.paddr == ADDR_STAT) ? apb.pwdata : '0;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            mask_q <= RST_VAL;
            stat_q <= RST_VAL;
            edge_q <= RST_VAL;
            hist_q <= RST_VAL;
            irq    <= 1'b0;
        end else begin
            hist_q <= in_sync;
            // A new event on the same cycle as its W1C keeps the bit set.
            stat_q <= (stat_q & ~w1c) | evt;
            irq    <= |(stat_q & mask_q);
            if (wr_en && apb.paddr == ADDR_MASK) mask_q <= apb.pwdata;
            if (wr_en && apb.paddr == ADDR_EDGE) edge_q <= apb.pwdata;
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (apb.paddr)
            ADDR_OUT:  rd_mux = out_q;
            ADDR_DIR:  rd_mux = dir_q;
            ADDR_IN:   rd_mux = in_sync;
`ifdef GPIO_IRQ_EN
            ADDR_MASK: rd_mux = mask_q;
            ADDR_STAT: rd_mux = stat_q;
            ADDR_EDGE: rd_mux = edge_q;
`endif
            default:   rd_mux = '0;
        endcase
    end

    // pready doubles as the wait-state flop; prdata is only non-zero alongside it.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            apb.pready <= 1'b0;
            apb.prdata <= '0;
        end else if (access && !apb.pready) begin
            apb.pready <= 1'b1;
            apb.prdata <= rd_mux;
        end else begin
            apb.pready <= 1'b0;
            apb.prdata <= '0;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            out_q <= RST_VAL;
            dir_q <= RST_VAL;
        end else if (wr_en) begin
            case (apb.paddr)
                ADDR_OUT: out_q <= apb.pwdata;
                ADDR_DIR: dir_q <= apb.pwdata;
                ADDR_SET: out_q <= out_q | apb.pwdata;
                ADDR_CLR: out_q <= out_q & ~apb.pwdata;
                default:  ;
            endcase
        end
    end

    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;

endmodule
